// File: rtl/hit_stop_ctrl.sv
// Game-state controller: per-frame collision resolution, lives/score keeping,
// and a hit-stop freeze that drives the sprite movers and the renderer tint.
module hit_stop_ctrl #(
  parameter int LIVES       = 3,
  parameter int STOP_FRAMES = 30,
  parameter int SCORE_DIV   = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       goose,
  input  logic       bean,
  input  logic       start,
  output logic       freeze,
  output logic       hit_flash,
  output logic       hit_pulse,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic       game_over
);

  typedef enum logic [1:0] {IDLE, RUN, HITSTOP, OVER} state_t;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [7:0] STOP_INIT  = 8'(STOP_FRAMES);
  localparam logic [7:0] DIV_LAST   = 8'(SCORE_DIV - 1);

  state_t     state, state_nxt;
  logic [7:0] frame_cnt, frame_nxt;
  logic [7:0] stop_cnt, stop_nxt;
  logic [1:0] lives_nxt;
  logic [7:0] score_nxt;
  logic       pulse_nxt, freeze_nxt, hit_flash_nxt, game_over_nxt;

  logic tick_cmp, tick_cmp_d, fr_tick;
  logic start_d, start_rise;
  logic visible_hit, coll_seen;
  logic restart;

  assign tick_cmp    = (x == 10'd0) && (y == 10'd480);
  assign visible_hit = goose && bean && (x < 10'd640) && (y < 10'd480);
  assign restart     = start_rise && ((state == IDLE) || (state == OVER));

  // The compare and start history reset to "already seen" so that a level
  // still present at reset release is not mistaken for a fresh edge.
  // NOTE: all clocked state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cmp_d <= 1'b1;
      fr_tick    <= 1'b0;
      start_d    <= 1'b1;
      start_rise <= 1'b0;
    end else begin
      tick_cmp_d <= tick_cmp;
      fr_tick    <= tick_cmp && !tick_cmp_d;
      start_d    <= start;
      start_rise <= start && !start_d;
    end
  end

  // One collision per frame at most; overlaps during the freeze never count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                  coll_seen <= 1'b0;
    else if (state == HITSTOP)   coll_seen <= 1'b0;
    else if (restart || fr_tick) coll_seen <= 1'b0;
    else if (visible_hit)        coll_seen <= 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      frame_cnt <= 8'd0;
      stop_cnt  <= 8'd0;
      lives     <= LIVES_INIT;
      score     <= 8'd0;
      hit_pulse <= 1'b0;
      freeze    <= 1'b1;
      hit_flash <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_cnt <= frame_nxt;
      stop_cnt  <= stop_nxt;
      lives     <= lives_nxt;
      score     <= score_nxt;
      hit_pulse <= pulse_nxt;
      freeze    <= freeze_nxt;
      hit_flash <= hit_flash_nxt;
      game_over <= game_over_nxt;
    end
  end

  // NOTE: every target gets a hold default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    frame_nxt = frame_cnt;
    stop_nxt  = stop_cnt;
    lives_nxt = lives;
    score_nxt = score;
    pulse_nxt = 1'b0;
    case (state)
      IDLE, OVER: begin
        if (start_rise) begin
          state_nxt = RUN;
          lives_nxt = LIVES_INIT;
          score_nxt = 8'd0;
          frame_nxt = 8'd0;
          stop_nxt  = 8'd0;
        end
      end
      RUN: begin
        if (fr_tick) begin
          if (coll_seen) begin
            pulse_nxt = 1'b1;
            lives_nxt = lives - 2'd1;
            if (lives == 2'd1) begin
              state_nxt = OVER;
            end else begin
              state_nxt = HITSTOP;
              stop_nxt  = STOP_INIT;
            end
          end else if (frame_cnt == DIV_LAST) begin
            frame_nxt = 8'd0;
            if (score != 8'hFF) score_nxt = score + 8'd1;
          end else begin
            frame_nxt = frame_cnt + 8'd1;
          end
        end
      end
      HITSTOP: begin
        if (fr_tick) begin
          if (stop_cnt == 8'd1) begin
            state_nxt = RUN;
            stop_nxt  = 8'd0;
          end else begin
            stop_nxt = stop_cnt - 8'd1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they leave the flops aligned
  // with the state register.
  always_comb begin
    freeze_nxt    = (state_nxt != RUN);
    hit_flash_nxt = (state_nxt == HITSTOP) && stop_nxt[1];
    game_over_nxt = (state_nxt == OVER);
  end

endmodule

// File: tb/tb_hit_stop_ctrl.sv
// Directed bench for hit_stop_ctrl: a frame-level game model pushes expected
// outputs per frame tick, popped and compared when the DUT outputs are due.
module tb_hit_stop_ctrl;

  localparam int LIVES       = 3;
  localparam int STOP_FRAMES = 30;
  localparam int SCORE_DIV   = 60;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic [9:0] x     = 10'd0;
  logic [9:0] y     = 10'd0;
  logic       goose = 1'b0;
  logic       bean  = 1'b0;
  logic       start = 1'b1;
  logic       freeze, hit_flash, hit_pulse, game_over;
  logic [1:0] lives;
  logic [7:0] score;

  always #5 clk = ~clk;

  hit_stop_ctrl #(.LIVES(LIVES), .STOP_FRAMES(STOP_FRAMES), .SCORE_DIV(SCORE_DIV)) dut (
    .clk(clk), .reset(reset), .x(x), .y(y), .goose(goose), .bean(bean), .start(start),
    .freeze(freeze), .hit_flash(hit_flash), .hit_pulse(hit_pulse),
    .lives(lives), .score(score), .game_over(game_over)
  );

  int checks   = 0;
  int failures = 0;
  int pulse_cnt = 0;

  always @(negedge clk) if (hit_pulse === 1'b1) pulse_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  typedef enum {M_IDLE, M_RUN, M_HS, M_OVER} mstate_t;
  typedef struct {
    int lives;
    int score;
    bit freeze;
    bit flash;
    bit over;
    bit pulse;
  } exp_t;

  mstate_t m_state;
  int      m_lives, m_score, m_fc, m_sc, m_hits;
  exp_t    sb[$];

  task automatic push_expected(input bit pulse);
    exp_t e;
    e.lives  = m_lives;
    e.score  = m_score;
    e.freeze = (m_state != M_RUN);
    e.flash  = (m_state == M_HS) && ((m_sc & 2) != 0);
    e.over   = (m_state == M_OVER);
    e.pulse  = pulse;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    m_state = M_IDLE; m_lives = LIVES; m_score = 0; m_fc = 0; m_sc = 0;
    push_expected(1'b0);
  endtask

  task automatic model_start();
    m_state = M_RUN; m_lives = LIVES; m_score = 0; m_fc = 0; m_sc = 0;
    push_expected(1'b0);
  endtask

  task automatic model_tick(input bit coll);
    bit hit = 1'b0;
    case (m_state)
      M_RUN: begin
        if (coll) begin
          hit = 1'b1;
          m_hits++;
          if (m_lives == 1) begin m_state = M_OVER; m_lives = 0; end
          else begin m_lives--; m_state = M_HS; m_sc = STOP_FRAMES; end
        end else if (m_fc == SCORE_DIV - 1) begin
          m_fc = 0;
          if (m_score < 255) m_score++;
        end else begin
          m_fc++;
        end
      end
      M_HS: begin
        if (m_sc == 1) begin m_state = M_RUN; m_sc = 0; end
        else m_sc--;
      end
      default: ;
    endcase
    push_expected(hit);
  endtask

  task automatic compare_outputs(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s scoreboard entries observed=0 expected=1", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_lives"},  32'(lives),     32'(e.lives));
      check({tag, "_score"},  32'(score),     32'(e.score));
      check({tag, "_freeze"}, 32'(freeze),    32'(e.freeze));
      check({tag, "_flash"},  32'(hit_flash), 32'(e.flash));
      check({tag, "_over"},   32'(game_over), 32'(e.over));
      check({tag, "_pulse"},  32'(hit_pulse), 32'(e.pulse));
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame: optional overlap pixels, optional off-screen overlaps, then the
  // x==0,y==480 position (held 4 clk unless fast) that produces the tick.
  task automatic frame(input string tag, input int n_ovl, input bit offscr, input bit fast);
    if (!fast) begin
      for (int i = 0; i < n_ovl; i++) begin
        x = 10'(100 + i); y = 10'd200; goose = 1'b1; bean = 1'b1;
        step();
      end
      if (offscr) begin
        x = 10'd700; y = 10'd100; goose = 1'b1; bean = 1'b1; step();
        x = 10'd100; y = 10'd500; step();
      end
      goose = 1'b0; bean = 1'b0; x = 10'd50; y = 10'd10;
      step();
    end
    model_tick(n_ovl > 0);
    x = 10'd0; y = 10'd480;
    step();
    step();
    compare_outputs(tag);
    if (!fast) begin
      step();
      check({tag, "_pulse_width"}, 32'(hit_pulse), 32'd0);
      step();
    end
    x = 10'd1;
    step();
  endtask

  task automatic press_start(input string tag);
    start = 1'b0;
    step();
    start = 1'b1;
    step();
    check({tag, "_edge_cycle"}, 32'(freeze), 32'd1);
    step();
    model_start();
    compare_outputs(tag);
  endtask

  initial begin
    m_hits = 0;
    model_reset();
    #20 reset = 1'b1;
    repeat (3) step();
    compare_outputs("reset");
    frame("idle_held_start", 0, 1'b0, 1'b0);

    press_start("start");

    repeat (120) frame("score", 0, 1'b0, 1'b0);
    check("score_after_120", 32'(score), 32'd2);

    frame("hit", 51, 1'b0, 1'b0);
    while (m_state == M_HS) frame("hitstop", 3, 1'b0, 1'b0);
    frame("after_hitstop", 0, 1'b0, 1'b0);
    check("hits_single", 32'(pulse_cnt), 32'(m_hits));

    frame("offscreen", 0, 1'b1, 1'b0);
    check("hits_offscreen", 32'(pulse_cnt), 32'(m_hits));

    while (m_score < 255) frame("sat_fill", 0, 1'b0, 1'b1);
    repeat (60) frame("sat_hold", 0, 1'b0, 1'b1);
    check("score_saturated", 32'(score), 32'd255);

    frame("hit2", 4, 1'b0, 1'b0);
    while (m_sc != 12) frame("hitstop2", 2, 1'b0, 1'b0);
    x = 10'd100; y = 10'd200; goose = 1'b1; bean = 1'b1;
    step();
    #2 reset = 1'b0;
    #1;
    model_reset();
    compare_outputs("async_reset");
    goose = 1'b0; bean = 1'b0; x = 10'd0; y = 10'd480;
    step();
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("no_spurious_tick", 32'(dut.fr_tick), 32'd0);
    end
    x = 10'd1;
    step();

    press_start("restart");
    repeat (3) begin
      frame("go_hit", 5, 1'b0, 1'b0);
      while (m_state == M_HS) frame("go_hitstop", 2, 1'b0, 1'b0);
    end
    frame("over_hold", 3, 1'b0, 1'b0);
    check("hits_total", 32'(pulse_cnt), 32'(m_hits));
    press_start("over_restart");
    frame("run_after_over", 0, 1'b0, 1'b0);
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hit_stop_ctrl.md
# hit_stop_ctrl

Game-state controller that sits directly downstream of the pixel renderer. It consumes the per-pixel goose/bean sprite flags and the vga_sync scan position. It resolves collisions once per frame, manages lives and score, and runs a hit-stop freeze after each hit. Its freeze and flash outputs feed back to the sprite movers and the renderer, replacing the free-running sticky hit flag.

## Interface
Parameters:
- LIVES, 3: lives at game start; legal range 1..3.
- STOP_FRAMES, 30: hit-stop length in frames; legal range 1..255.
- SCORE_DIV, 60: RUN frames per score point; legal range 1..255.

Ports:
- clk  in  1  system clock (100 MHz).
- reset  in  1  asynchronous, active-low reset.
- x  in  10  current pixel column from vga_sync.
- y  in  10  current pixel row from vga_sync.
- goose  in  1  goose sprite covers the current pixel.
- bean  in  1  bean sprite covers the current pixel.
- start  in  1  start/restart button level, already synchronised.
- freeze  out  1  1 = sprite movers hold position.
- hit_flash  out  1  1 = renderer tints the goose.
- hit_pulse  out  1  one-cycle pulse when a hit is registered.
- lives  out  2  remaining lives.
- score  out  8  score, saturating.
- game_over  out  1  1 in OVER state.

## Operation
- **Frame tick:** fr_tick is registered. It asserts for exactly one cycle, in the cycle after the first cycle in which x==0 && y==480 (edge detect on that compare, because x is held for 4 clk per pixel).
- **Collision latch:** coll_seen sets on any cycle with goose && bean && x<640 && y<480. It clears on fr_tick. While in HITSTOP, coll_seen is forced to 0.
- **Start edge:** start_rise = start && !start_d. start_d resets to 1, so a button held through reset does not start a game.
- **State machine:** states IDLE, RUN, HITSTOP, OVER.
  - IDLE: freeze=1. On start_rise go to RUN and load lives=LIVES, score=0, frame_cnt=0, stop_cnt=0, and clear coll_seen.
  - RUN: freeze=0. On fr_tick with coll_seen=1:
    - pulse hit_pulse and decrement lives;
    - if lives was 1, go to OVER (lives becomes 0);
    - otherwise go to HITSTOP with stop_cnt=STOP_FRAMES.
  - RUN: on fr_tick with coll_seen=0, frame_cnt increments. When frame_cnt reaches SCORE_DIV-1 it wraps to 0 and score increments, saturating at 255.
  - HITSTOP: freeze=1, hit_flash=stop_cnt[1]. On fr_tick stop_cnt decrements. On the tick where stop_cnt==1, go to RUN with stop_cnt=0. Score and frame_cnt hold.
  - OVER: freeze=1, game_over=1, lives=0, score holds. On start_rise reload exactly as from IDLE and go to RUN.
- start_rise is ignored in RUN and HITSTOP.
- If start_rise and fr_tick occur in the same cycle in IDLE or OVER, start wins: the tick has no effect and the counters start fresh.
- A collision and fr_tick never coincide, because the tick occurs at y==480, which is outside the visible qualifier.

## Timing
- All outputs are registered.
- Reset values: state IDLE, freeze=1, hit_flash=0, hit_pulse=0, lives=LIVES, score=0, game_over=0, and all internal counters 0.
- Latency:
  - The collision pixel itself has no output effect.
  - hit_pulse, lives, and state changes appear 1 cycle after fr_tick, i.e. 2 cycles after x==0,y==480 is first presented.
  - start_rise to freeze=0 takes 2 cycles from the start rising edge (one cycle of edge detect, then the state register).
- When reset asserts mid-frame or mid-HITSTOP, all outputs return to reset values immediately (asynchronously). The first fr_tick after reset release requires a fresh entry of y==480.
- hit_pulse is high for exactly one clk per registered hit. Because coll_seen is latched, there is at most one hit per frame regardless of overlapping pixel count.

## Test plan
- **Reset/start:** reset=0 then release, start held 1 → freeze=1, lives=3, score=0, no RUN. Then start 0→1 → RUN, with freeze=0 2 cycles later.
- **Scoring:** RUN, no overlap, 120 frames → score=2. Drive score to 255, then 60 more frames → score stays 255.
- **Single hit:** one overlap pixel at (100,200) plus 50 more overlap pixels in the same frame → exactly one hit_pulse 1 cycle after fr_tick, lives 3→2, freeze=1 for 30 frames, hit_flash toggling every 2 frames, and overlaps during HITSTOP ignored. The 31st frame is back in RUN with score unchanged.
- **Game over:** LIVES=1, one overlap frame → game_over=1, lives=0, freeze=1. start_rise → lives=1, score=0, RUN.
- **Off-screen filter:** goose&&bean asserted only at x=700 or y=500 → no hit, lives unchanged.
- **Async reset mid-HITSTOP:** reset=0 at stop_cnt=12 → outputs immediately at reset values, state IDLE, and no spurious fr_tick while y stays 480 after release.
